// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, with a
// start/done handshake and a busy stall output.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish early once the
// remaining multiplier bits are all zero (results unchanged, latency shorter).
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 op_div;
  logic                 neg_q;
  logic                 rneg_q;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;

  logic                 accept;
  logic                 a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_tmp, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_step;
  logic [2*WIDTH-1:0]   calc_next;
  logic                 early;
  logic [2*WIDTH-1:0]   prod;

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // Request acceptance and operand magnitude/sign preparation.
  always_comb begin
    accept = start && ((state == IDLE) || (state == DONE));
    a_neg  = op[0] & src_a[WIDTH-1];
    b_neg  = op[0] & src_b[WIDTH-1];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;
    b_zero = op[1] && (src_b == '0);
  end

  // One iteration step of each algorithm; acc = {upper, lower} halves.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    mul_step  = {mul_sum, acc[WIDTH-1:1]};
    div_tmp   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_tmp - {1'b0, opnd};
    div_ge    = ~div_diff[WIDTH];
    div_step  = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ge};
    prod      = neg_q ? -acc : acc;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-2:0] rest_mask;
  // Multiplier bits still to be consumed after this step are acc[cnt:1];
  // if none are set, the remaining cnt shifts are applied in one go.
  always_comb begin
    rest_mask = ~({(WIDTH-1){1'b1}} << cnt);
    early     = !op_div && ((acc[WIDTH-1:1] & rest_mask) == '0);
    calc_next = op_div ? div_step : (early ? (mul_step >> cnt) : mul_step);
  end
`else
  // Fixed-length iteration for every operation.
  always_comb begin
    early     = 1'b0;
    calc_next = op_div ? div_step : mul_step;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)      state_nxt = b_zero ? DONE : CALC;
        else            state_nxt = IDLE;
      end
      CALC: if ((cnt == '0) || early) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on acceptance, iterate in CALC, sign-correct in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      op_div   <= op[1];
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      cnt      <= '1;
      div_zero <= b_zero;
      opnd     <= op[1] ? b_mag : a_mag;
      acc      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      if (b_zero) begin
        hi <= src_a;
        lo <= '1;
      end
    end else begin
      case (state)
        CALC: begin
          acc <= calc_next;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (op_div) begin
            lo <= neg_q  ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            hi <= rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: scoreboard of expected results (value and done
// cycle) checked by an independent monitor on the falling clock edge.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic last_was_done = 1'b0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    longint sa, sb2, q, r;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    e.dz = 1'b0;
    e.cyc = 0;
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = sa * sb2; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin e.hi = a; e.lo = '1; e.dz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: begin
        if (b == 0) begin e.hi = a; e.lo = '1; e.dz = 1'b1; end
        else begin
          q = sa / sb2; r = sa % sb2;
          p = q; e.lo = p[31:0];
          p = r; e.hi = p[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Wait for the unit to accept, push expectation, pulse start for one edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) begin
      chk("issue_wait_timeout", 64'(busy), 64'd0);
      return;
    end
    e = model(o, a, b);
    e.cyc = e.dz ? cyc + 1 : cyc + 34;
    last_was_done = done;
    sb.push_back(e);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Monitor: compare on each done pulse; flag late results and overlap.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done || busy) chk("done_busy_exclusive", 64'(done & busy), 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_zero", 64'(div_zero), 64'(e.dz));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        chk("done_timeout", 64'(cyc), 64'(sb[0].cyc));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    int n;

    // Reset values
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // MULTU max*max with busy window over 33 cycles
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      chk("busy_window", 64'({busy, done}), 64'(2'b10));
    end

    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'd100, 32'd0);
    repeat (4) @(negedge clk);
    chk("dz_held", 64'(div_zero), 64'd1);
    issue(2'b10, 32'd100, 32'd7);

    // Start while busy is ignored
    issue(2'b00, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;

    // Back-to-back: the next start lands in the done cycle
    issue(2'b01, 32'h1234_5678, 32'hFEDC_BA98);
    chk("back_to_back", 64'(last_was_done), 64'd1);
    issue(2'b10, 32'hDEAD_BEEF, 32'd3);

    // Reset in the middle of a divide
    issue(2'b11, 32'h7654_3210, 32'd13);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Randomized traffic, mixing back-to-back and idle gaps
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = $urandom_range(0, 15);
        2: a = 32'h8000_0000;
        3: b = '1;
        default: ;
      endcase
      issue(o, a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
